// File: rtl/osc_freq_meter_if.sv
// Purpose: control/result bundle between a frequency-meter client and the meter.
// Latency: wires only, no storage.
// Backpressure: none; the client sees busy and must not expect start to queue.
interface osc_freq_meter_if #(
  parameter int unsigned COUNT_W = 24
);
  logic               sig_in;
  logic               start;
  logic               abort;
  logic               continuous;
  logic               busy;
  logic               valid;
  logic [COUNT_W-1:0] freq_count;
  logic               overflow;

  modport master (
    output sig_in, start, abort, continuous,
    input  busy, valid, freq_count, overflow
  );

  modport slave (
    input  sig_in, start, abort, continuous,
    output busy, valid, freq_count, overflow
  );
endinterface

// File: rtl/osc_freq_meter.sv
// Purpose: counts rising edges of an asynchronous signal over a fixed gate window of clk cycles.
// Latency: start -> GATE_CYCLES gate cycles -> result with valid one cycle later; sig_in adds 3 cycles.
// Backpressure: none; valid is a one-cycle pulse, start is ignored while busy, abort cancels.
module osc_freq_meter #(
  parameter int unsigned GATE_CYCLES = 7000000,
  parameter int unsigned COUNT_W     = 24
) (
  input logic             clk,
  input logic             rst,
  osc_freq_meter_if.slave bus
);

  // Gate counter sized to hold GATE_CYCLES itself, so the final increment never wraps.
  localparam int GATE_W = $clog2(64'(GATE_CYCLES) + 64'd1);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               strobe;
  logic [GATE_W-1:0]  gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               sticky;
  logic [COUNT_W-1:0] edge_next;
  logic               sticky_next;
  logic               busy_q;
  logic               valid_q;
  logic [COUNT_W-1:0] freq_q;
  logic               ovf_q;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe = s2 & ~s3;

  // Saturating edge count; a strobe that cannot be counted marks the window as overflowed.
  always_comb begin
    edge_next   = edge_cnt;
    sticky_next = sticky;
    if (strobe) begin
      if (edge_cnt == CNT_MAX) begin
        sticky_next = 1'b1;
      end else begin
        edge_next = edge_cnt + 1'b1;
      end
    end
  end

  // Measurement FSM; the result is latched on the last gate cycle so valid and data
  // appear together in the DONE cycle. An abort landing in DONE only cancels the restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sticky   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      freq_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state    <= GATE;
            busy_q   <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sticky   <= 1'b0;
          end
        end
        GATE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_next;
            sticky   <= sticky_next;
            if (gate_cnt == GATE_LAST) begin
              state   <= DONE;
              valid_q <= 1'b1;
              freq_q  <= edge_next;
              ovf_q   <= sticky_next;
            end
          end
        end
        DONE: begin
          if (bus.abort || !bus.continuous) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sticky   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.freq_count = freq_q;
  assign bus.overflow   = ovf_q;

endmodule
